// File: rtl/regfile_param_if.sv
// Register-file bus: two asynchronous read ports, one write port,
// and the sequential-clear request/status handshake.
interface regfile_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [ADDR_W-1:0] WriteRegister;
  logic              RegWrite;
  logic              ClearReq;
  logic              Busy;
  logic              ClearDone;

  modport master (
    output WriteData, ReadRegister1, ReadRegister2, WriteRegister, RegWrite, ClearReq,
    input  ReadData1, ReadData2, Busy, ClearDone
  );

  modport slave (
    input  WriteData, ReadRegister1, ReadRegister2, WriteRegister, RegWrite, ClearReq,
    output ReadData1, ReadData2, Busy, ClearDone
  );
endinterface

// File: rtl/regfile_param.sv
// Parameterised 2-read/1-write register file with a sequential clear engine.
// Optional macro REGFILE_BYPASS_EN forwards an accepted write to matching read ports.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic            Clk,
  input logic            reset,
  regfile_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] counterQ, counterD;
  logic              clearDoneQ, clearDoneD;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic              zeroRegEn;
  logic              writeHitsZero;
  logic              writeAccept;
  logic              writeEffective;
  logic [WIDTH-1:0]  readData1, readData2;

  assign zeroRegEn      = (ZERO_REG != 0);
  assign writeHitsZero  = zeroRegEn && (bus.WriteRegister == '0);
  // Writes arriving during a clear are dropped outright, never queued.
  assign writeAccept    = bus.RegWrite && (stateQ == IDLE);
  assign writeEffective = writeAccept && !writeHitsZero;

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      stateQ     <= IDLE;
      counterQ   <= '0;
      clearDoneQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      counterQ   <= counterD;
      clearDoneQ <= clearDoneD;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    stateD     = stateQ;
    counterD   = counterQ;
    clearDoneD = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (bus.ClearReq) begin
          stateD   = CLEAR;
          counterD = '0;
        end
      end
      CLEAR: begin
        if (counterQ == LastAddr) begin
          stateD     = IDLE;
          counterD   = '0;
          clearDoneD = 1'b1;
        end else begin
          counterD = counterQ + 1'b1;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: the array is reset because reset must zero every entry; this forces flops, not RAM.
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (stateQ == CLEAR) begin
      regs[counterQ] <= '0;
    end else if (writeEffective) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  always_comb begin
    readData1 = regs[bus.ReadRegister1];
`ifdef REGFILE_BYPASS_EN
    if (writeEffective && (bus.WriteRegister == bus.ReadRegister1)) begin
      readData1 = bus.WriteData;
    end
`endif
    if (zeroRegEn && (bus.ReadRegister1 == '0)) begin
      readData1 = '0;
    end
  end

  always_comb begin
    readData2 = regs[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (writeEffective && (bus.WriteRegister == bus.ReadRegister2)) begin
      readData2 = bus.WriteData;
    end
`endif
    if (zeroRegEn && (bus.ReadRegister2 == '0)) begin
      readData2 = '0;
    end
  end

  assign bus.ReadData1 = readData1;
  assign bus.ReadData2 = readData2;
  assign bus.Busy      = (stateQ == CLEAR);
  assign bus.ClearDone = clearDoneQ;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (default parameters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_regfile_param;

  logic Clk;
  logic reset;
  int   checks;
  int   errors;
  int   busyCycles;
  int   doneCount;

  regfile_param_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  regfile_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    bus.WriteRegister = addr;
    bus.WriteData     = data;
    bus.RegWrite      = 1'b1;
    tick();
    bus.RegWrite      = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset             = 1'b0;
    bus.WriteData     = '0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
    bus.WriteRegister = '0;
    bus.RegWrite      = 1'b0;
    bus.ClearReq      = 1'b0;

    // Reset for one edge, then every address reads zero.
    tick();
    reset = 1'b1;
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_done", {31'd0, bus.ClearDone}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      bus.ReadRegister2 = 5'(31 - i);
      #1;
      check("reset_rd1", bus.ReadData1, 32'd0);
      check("reset_rd2", bus.ReadData2, 32'd0);
    end

    // Basic write, then zero register protection.
    writeReg(5'd7, 32'hDEADBEEF);
    bus.ReadRegister1 = 5'd7;
    bus.ReadRegister2 = 5'd0;
    #1;
    check("wr7_rd1", bus.ReadData1, 32'hDEADBEEF);
    check("rd0_rd2", bus.ReadData2, 32'd0);
    writeReg(5'd0, 32'h1234);
    bus.ReadRegister1 = 5'd0;
    #1;
    check("wr0_discarded", bus.ReadData1, 32'd0);

    // Fill 1..31 with value = address.
    for (int a = 1; a < 32; a++) begin
      writeReg(5'(a), 32'(a));
    end
    bus.ReadRegister1 = 5'd31;
    bus.ReadRegister2 = 5'd20;
    #1;
    check("fill_31", bus.ReadData1, 32'd31);
    check("fill_20", bus.ReadData2, 32'd20);

    // Full clear with a dropped write in clear cycle 5.
    bus.ClearReq = 1'b1;
    tick();
    bus.ClearReq = 1'b0;
    busyCycles = 0;
    for (int c = 0; c < 40 && bus.Busy; c++) begin
      busyCycles++;
      check("clear_rd31_old", bus.ReadData1, 32'd31);
      check("clear_no_done", {31'd0, bus.ClearDone}, 32'd0);
      bus.WriteRegister = 5'd20;
      bus.WriteData     = 32'hAAAA;
      bus.RegWrite      = (busyCycles == 5);
      if (busyCycles == 10) begin
        bus.ReadRegister2 = 5'd20;
        #1;
        check("clear_wr_dropped", bus.ReadData2, 32'd20);
      end
      if (busyCycles == 11) begin
        bus.ReadRegister2 = 5'd5;
        #1;
        check("clear_partial_5", bus.ReadData2, 32'd0);
      end
      tick();
    end
    bus.RegWrite = 1'b0;
    check("clear_busy_cycles", 32'(busyCycles), 32'd32);
    check("clear_busy_low", {31'd0, bus.Busy}, 32'd0);
    check("clear_rd31_zero", bus.ReadData1, 32'd0);
    doneCount = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.ClearDone) doneCount++;
      tick();
    end
    check("clear_done_once", 32'(doneCount), 32'd1);
    for (int i = 0; i < 32; i++) begin
      bus.ReadRegister1 = 5'(i);
      #1;
      check("clear_all_zero", bus.ReadData1, 32'd0);
    end

    // Reset in clear cycle 10 abandons the clear.
    writeReg(5'd3, 32'h33);
    writeReg(5'd25, 32'h25);
    writeReg(5'd31, 32'h31);
    bus.ClearReq = 1'b1;
    tick();
    bus.ClearReq = 1'b0;
    busyCycles = 0;
    for (int c = 0; c < 40 && bus.Busy && busyCycles < 10; c++) begin
      busyCycles++;
      if (busyCycles == 10) reset = 1'b0;
      tick();
    end
    reset = 1'b1;
    check("rst_mid_reached", 32'(busyCycles), 32'd10);
    check("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
    bus.ReadRegister1 = 5'd25;
    bus.ReadRegister2 = 5'd31;
    #1;
    check("rst_mid_25", bus.ReadData1, 32'd0);
    check("rst_mid_31", bus.ReadData2, 32'd0);
    doneCount = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.ClearDone) doneCount++;
      tick();
    end
    check("rst_mid_no_done", 32'(doneCount), 32'd0);

    // Same-cycle visibility of an accepted write.
    bus.ReadRegister1 = 5'd3;
    bus.ReadRegister2 = 5'd3;
    bus.WriteRegister = 5'd3;
    bus.WriteData     = 32'h55;
    bus.RegWrite      = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", bus.ReadData1, 32'h55);
`else
    check("nobypass_same_cycle", bus.ReadData1, 32'd0);
`endif
    tick();
    bus.RegWrite = 1'b0;
    check("after_edge_rd1", bus.ReadData1, 32'h55);
    check("after_edge_rd2", bus.ReadData2, 32'h55);
    bus.ReadRegister1 = 5'd0;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 32'h99;
    bus.RegWrite      = 1'b1;
    #1;
    check("zero_no_bypass", bus.ReadData1, 32'd0);
    tick();
    bus.RegWrite = 1'b0;

    // Write and clear request on the same edge: write lands, then gets cleared.
    bus.WriteRegister = 5'd9;
    bus.WriteData     = 32'h77;
    bus.RegWrite      = 1'b1;
    bus.ClearReq      = 1'b1;
    tick();
    bus.RegWrite      = 1'b0;
    bus.ClearReq      = 1'b0;
    bus.ReadRegister1 = 5'd9;
    #1;
    check("wrclr_busy", {31'd0, bus.Busy}, 32'd1);
    check("wrclr_written", bus.ReadData1, 32'h77);
    busyCycles = 0;
    for (int c = 0; c < 40 && bus.Busy; c++) begin
      busyCycles++;
      tick();
    end
    check("wrclr_cycles", 32'(busyCycles), 32'd32);
    check("wrclr_done", {31'd0, bus.ClearDone}, 32'd1);
    check("wrclr_zeroed", bus.ReadData1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 32: data width of every entry, in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1: when 1, entry 0 is a constant-zero register.
REQ-004 Port Clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1: synchronous, active-low reset, sampled on the Clk rising edge.
REQ-006 Port ReadData1  output  WIDTH: read port 1 data.
REQ-007 Port ReadData2  output  WIDTH: read port 2 data.
REQ-008 Port WriteData  input  WIDTH: write data.
REQ-009 Port ReadRegister1  input  ADDR_W: read port 1 address.
REQ-010 Port ReadRegister2  input  ADDR_W: read port 2 address.
REQ-011 Port WriteRegister  input  ADDR_W: write address.
REQ-012 Port RegWrite  input  1: write enable, active high.
REQ-013 Port ClearReq  input  1: request to zero all entries sequentially.
REQ-014 Port Busy  output  1: high while the clear sequence runs.
REQ-015 Port ClearDone  output  1: one-cycle pulse when the clear sequence finishes.

Function
REQ-016 Reads shall be asynchronous: ReadDataN = entry[ReadRegisterN], combinational, with no clock latency.
REQ-017 With ZERO_REG=1, a read of address 0 shall return 0, and writes to address 0 shall be discarded.
REQ-018 A write is accepted when RegWrite=1 and Busy=0; entry[WriteRegister] shall take WriteData at that rising edge.
REQ-019 While Busy=1, RegWrite shall be ignored: the write is dropped and not queued.
REQ-020 FSM states: IDLE, CLEAR.
- Reset state: IDLE.
- IDLE -> CLEAR on the edge where ClearReq=1; counter is loaded with 0.
- CLEAR -> IDLE on the edge that zeros entry DEPTH-1.
REQ-021 In CLEAR, each rising edge shall zero entry[counter] and then increment counter; a full clear takes exactly DEPTH cycles with Busy=1.
REQ-022 Busy shall be 1 exactly when the FSM is in CLEAR.
REQ-023 ClearDone shall be 1 for exactly the one cycle after the CLEAR -> IDLE transition, and 0 otherwise.
REQ-024 ClearReq while Busy=1 shall be ignored; ClearReq held high in IDLE shall start a new clear each time IDLE is re-entered.
REQ-025 RegWrite and ClearReq both high in IDLE: the write completes at that edge and the clear starts, so the written entry is zeroed later.
REQ-026 The counter shall be ADDR_W bits wide and shall not wrap inside one sequence.
REQ-027 Reads during CLEAR shall return current contents: entries already cleared read 0, entries not yet cleared read their old values.

Reset
REQ-028 When reset=0 at a rising edge, the block shall set:
- all entries to 0;
- FSM to IDLE and counter to 0;
- Busy=0 and ClearDone=0.
REQ-029 Reset shall take priority over RegWrite, ClearReq and an in-progress clear; an interrupted clear is abandoned without a ClearDone pulse.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: when a write is accepted (REQ-018) to a non-zero-register address equal to ReadRegisterN, ReadDataN shall return WriteData combinationally in that same cycle.
REQ-031 Macro REGFILE_BYPASS_EN undefined: ReadDataN shall return the stored value; the new value becomes visible only after the write edge.

Verification
REQ-032 Defaults. Reset low for 1 edge, then read all 32 addresses -> every read 0, Busy=0, ClearDone=0.
REQ-033 Write 0xDEADBEEF to address 7, then read port 1 at address 7 and port 2 at address 0 -> 0xDEADBEEF and 0. Write 0x1234 to address 0 -> address 0 still reads 0.
REQ-034 Fill addresses 1..31 with value=address, then pulse ClearReq -> Busy=1 for exactly 32 cycles, ClearDone pulses once, all entries read 0. Address 31 reads 31 until the final clear edge.
REQ-035 In clear cycle 5, write 0xAAAA to address 20 -> write dropped; address 20 reads 0 after ClearDone.
REQ-036 Drop reset low in clear cycle 10 -> next cycle Busy=0, all entries 0, no ClearDone pulse.
REQ-037 REGFILE_BYPASS_EN defined: write 0x55 to address 3 while ReadRegister1=3 -> ReadData1=0x55 in the same cycle. Undefined: the old value in that cycle, 0x55 after the edge.
